// File: rtl/e1_qadd_unpack.sv
// Unpacks E1 grouped-adder result groups into a serial lane stream through a two-slot buffer.
// Optional drop counter output is enabled by defining E1_QADD_UNPACK_DROPCNT_EN.
module e1_qadd_unpack #(
   parameter int Q   = 15,
   parameter int N   = 64,
   parameter int NUM = 4,
   localparam int LW = $clog2(NUM)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N*NUM-1:0] c,
   input  logic             c_valid,
   output logic [N-1:0]     out_data,
   output logic [LW-1:0]    out_lane,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             full,
   output logic             drop
`ifdef E1_QADD_UNPACK_DROPCNT_EN
   ,
   output logic [15:0]      drop_cnt
`endif
);

   if (NUM < 2) begin : g_bad_num
      $error("e1_qadd_unpack: NUM must be at least 2");
   end
   if (Q < 0 || Q >= N) begin : g_bad_q
      $error("e1_qadd_unpack: Q must lie within the lane width");
   end

   typedef enum logic {
      EMPTY  = 1'b0,
      STREAM = 1'b1
   } state_t;

   state_t        state;
   logic [N-1:0]  mem [2][NUM];
   logic          wp;
   logic          rp;
   logic [1:0]    cnt;
   logic [LW-1:0] lane;
   logic          beat;
   logic          pop;
   logic          accept;
   logic          overflow;

   assign out_valid = (state == STREAM);
   assign out_last  = out_valid && (lane == LW'(NUM - 1));
   assign out_data  = mem[rp][lane];
   assign out_lane  = lane;
   assign full      = (cnt == 2'd2);

   assign beat     = out_valid && out_ready;
   assign pop      = beat && out_last;
   // A pop frees a slot on the same edge, so a full buffer can still accept.
   assign accept   = c_valid && (!full || pop);
   assign overflow = c_valid && full && !pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= EMPTY;
         wp    <= 1'b0;
         rp    <= 1'b0;
         cnt   <= 2'd0;
         lane  <= '0;
         drop  <= 1'b0;
`ifdef E1_QADD_UNPACK_DROPCNT_EN
         drop_cnt <= 16'd0;
`endif
      end else begin
         drop <= overflow;
         cnt  <= cnt + {1'b0, accept} - {1'b0, pop};
         if (accept) wp <= ~wp;
         if (pop)    rp <= ~rp;
         if (beat)   lane <= pop ? '0 : lane + LW'(1);

         case (state)
            EMPTY:   if (accept) state <= STREAM;
            STREAM:  if (pop && !accept && cnt == 2'd1) state <= EMPTY;
            default: state <= EMPTY;
         endcase
`ifdef E1_QADD_UNPACK_DROPCNT_EN
         if (overflow && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
`endif
      end
   end

   // NOTE: the slot storage has no reset; validity is tracked by cnt/state, so clearing data would only cost area.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int i = 0; i < NUM; i++) mem[wp][i] <= c[i*N +: N];
      end
   end

endmodule

// File: tb/tb_e1_qadd_unpack.sv
// Self-checking bench for e1_qadd_unpack: directed table, corner sequences and random traffic against a queue model.
module tb_e1_qadd_unpack;
   localparam int N   = 64;
   localparam int NUM = 4;
   localparam int LW  = $clog2(NUM);

   typedef logic [N*NUM-1:0] grp_t;

   typedef struct {
      bit          cv;
      grp_t        cd;
      bit          rdy;
      bit          ev;
      logic [63:0] edata;
      int          elane;
      bit          elast;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   grp_t          c;
   logic          c_valid;
   logic [N-1:0]  out_data;
   logic [LW-1:0] out_lane;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
   logic          full;
   logic          drop;
`ifdef E1_QADD_UNPACK_DROPCNT_EN
   logic [15:0]   drop_cnt;
`endif

   always #5 clk = ~clk;

   e1_qadd_unpack #(.Q(15), .N(N), .NUM(NUM)) dut (
      .clk       (clk),
      .rst       (rst),
      .c         (c),
      .c_valid   (c_valid),
      .out_data  (out_data),
      .out_lane  (out_lane),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .full      (full),
      .drop      (drop)
`ifdef E1_QADD_UNPACK_DROPCNT_EN
      ,
      .drop_cnt  (drop_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Reference model: a queue of whole groups plus the lane position inside the head group.
   grp_t mq[$];
   int   m_lane;
   bit   m_drop;
   int   m_dcnt;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic grp_t mk(input logic [7:0] base, input logic [7:0] step);
      grp_t g;
      for (int i = 0; i < NUM; i++) g[i*N +: N] = 64'(base + step * 8'(i));
      return g;
   endfunction

   function automatic logic [63:0] lane_of(input grp_t g, input int i);
      return g[i*N +: N];
   endfunction

   function automatic grp_t rnd_grp();
      grp_t g;
      for (int i = 0; i < N*NUM/32; i++) g[i*32 +: 32] = $urandom;
      return g;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_lane = 0;
      m_drop = 1'b0;
      m_dcnt = 0;
   endtask

   task automatic model_edge(input bit cv, input grp_t cd, input bit rdy);
      bit v, pop, acc;
      v   = (mq.size() != 0);
      pop = v && rdy && (m_lane == NUM - 1);
      acc = cv && (mq.size() < 2 || pop);
      m_drop = cv && (mq.size() == 2) && !pop;
      if (m_drop && m_dcnt < 65535) m_dcnt++;
      if (v && rdy) begin
         if (pop) begin
            void'(mq.pop_front());
            m_lane = 0;
         end else begin
            m_lane++;
         end
      end
      if (acc) mq.push_back(cd);
   endtask

   task automatic model_check();
      bit v;
      v = (mq.size() != 0);
      check("m_valid", 64'(out_valid), 64'(v));
      if (v) check("m_data", out_data, lane_of(mq[0], m_lane));
      check("m_lane", 64'(out_lane), 64'(m_lane));
      check("m_last", 64'(out_last), 64'(v && m_lane == NUM - 1));
      check("m_full", 64'(full), 64'(mq.size() == 2));
      check("m_drop", 64'(drop), 64'(m_drop));
`ifdef E1_QADD_UNPACK_DROPCNT_EN
      check("m_drop_cnt", 64'(drop_cnt), 64'(m_dcnt));
`endif
   endtask

   // Inputs are applied 1 time unit after an edge; outputs are compared 1 unit after the next edge.
   task automatic cycle(input bit cv, input grp_t cd, input bit rdy);
      c_valid   = cv;
      c         = cd;
      out_ready = rdy;
      model_edge(cv, cd, rdy);
      @(posedge clk);
      #1;
      model_check();
   endtask

   vec_t tbl[15];

   function automatic vec_t mkv(input bit cv, input grp_t cd, input bit rdy, input bit ev,
                                input logic [63:0] edata, input int elane, input bit elast);
      vec_t v;
      v.cv = cv; v.cd = cd; v.rdy = rdy; v.ev = ev;
      v.edata = edata; v.elane = elane; v.elast = elast;
      return v;
   endfunction

   initial begin
      grp_t g1, ga, gb, gc;
      logic [63:0] exp_seq[8];
      int drops_seen;

      g1 = mk(8'h11, 8'h11);
      ga = mk(8'hA0, 8'h01);
      gb = mk(8'hB0, 8'h01);
      gc = mk(8'hC0, 8'h01);

      // Single group at full rate, then the same group with a 5-cycle stall at lane 1.
      tbl[0]  = mkv(1, g1, 1, 1, 64'h11, 0, 0);
      tbl[1]  = mkv(0, '0, 1, 1, 64'h22, 1, 0);
      tbl[2]  = mkv(0, '0, 1, 1, 64'h33, 2, 0);
      tbl[3]  = mkv(0, '0, 1, 1, 64'h44, 3, 1);
      tbl[4]  = mkv(0, '0, 1, 0, 64'h0,  0, 0);
      tbl[5]  = mkv(1, g1, 1, 1, 64'h11, 0, 0);
      tbl[6]  = mkv(0, '0, 1, 1, 64'h22, 1, 0);
      for (int i = 7; i < 12; i++) tbl[i] = mkv(0, '0, 0, 1, 64'h22, 1, 0);
      tbl[12] = mkv(0, '0, 1, 1, 64'h33, 2, 0);
      tbl[13] = mkv(0, '0, 1, 1, 64'h44, 3, 1);
      tbl[14] = mkv(0, '0, 1, 0, 64'h0,  0, 0);

      rst = 1'b1; c = '0; c_valid = 1'b0; out_ready = 1'b0;
      model_reset();
      #12;
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_last",  64'(out_last),  64'd0);
      check("rst_full",  64'(full),      64'd0);
      check("rst_drop",  64'(drop),      64'd0);
      check("rst_lane",  64'(out_lane),  64'd0);
`ifdef E1_QADD_UNPACK_DROPCNT_EN
      check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
`endif
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 15; i++) begin
         cycle(tbl[i].cv, tbl[i].cd, tbl[i].rdy);
         check("tbl_valid", 64'(out_valid), 64'(tbl[i].ev));
         if (tbl[i].ev) check("tbl_data", out_data, tbl[i].edata);
         check("tbl_lane", 64'(out_lane), 64'(tbl[i].elane));
         check("tbl_last", 64'(out_last), 64'(tbl[i].elast));
      end

      // Overflow: A, B, C offered back to back with the consumer stalled.
      drops_seen = 0;
      cycle(1, ga, 0);
      check("ovf_full_1", 64'(full), 64'd0);
      cycle(1, gb, 0);
      check("ovf_full_2", 64'(full), 64'd1);
      drops_seen += int'(drop);
      cycle(1, gc, 0);
      check("ovf_drop_pulse", 64'(drop), 64'd1);
      drops_seen += int'(drop);
      cycle(0, '0, 0);
      check("ovf_drop_clear", 64'(drop), 64'd0);
      drops_seen += int'(drop);
      for (int k = 0; k < 8; k++) exp_seq[k] = (k < 4) ? lane_of(ga, k) : lane_of(gb, k - 4);
      for (int k = 0; k < 8; k++) begin
         check("ovf_order", out_data, exp_seq[k]);
         cycle(0, '0, 1);
         drops_seen += int'(drop);
      end
      check("ovf_drop_count", 64'(drops_seen), 64'd1);
      check("ovf_empty", 64'(out_valid), 64'd0);
`ifdef E1_QADD_UNPACK_DROPCNT_EN
      check("ovf_drop_cnt", 64'(drop_cnt), 64'd1);
`endif

      // Accept coinciding with the final pop of A while both slots are full.
      cycle(1, ga, 1);
      cycle(1, gb, 1);
      check("sim_full", 64'(full), 64'd1);
      cycle(0, '0, 1);
      cycle(0, '0, 1);
      check("sim_a_last", 64'(out_last), 64'd1);
      cycle(1, gc, 1);
      check("sim_no_drop", 64'(drop), 64'd0);
      check("sim_still_full", 64'(full), 64'd1);
      for (int k = 0; k < 8; k++) exp_seq[k] = (k < 4) ? lane_of(gb, k) : lane_of(gc, k - 4);
      for (int k = 0; k < 8; k++) begin
         check("sim_valid", 64'(out_valid), 64'd1);
         check("sim_order", out_data, exp_seq[k]);
         cycle(0, '0, 1);
      end
      check("sim_empty", 64'(out_valid), 64'd0);

      // Asynchronous reset in the middle of a group, between clock edges.
      cycle(1, ga, 1);
      cycle(0, '0, 1);
      #3;
      rst = 1'b1;
      #1;
      check("arst_valid", 64'(out_valid), 64'd0);
      check("arst_last",  64'(out_last),  64'd0);
      check("arst_full",  64'(full),      64'd0);
      check("arst_lane",  64'(out_lane),  64'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      cycle(1, gb, 1);
      check("arst_restart_lane", 64'(out_lane), 64'd0);
      check("arst_restart_data", out_data, lane_of(gb, 0));
      check("arst_no_drop", 64'(drop), 64'd0);

      // Random traffic against the model.
      for (int i = 0; i < 800; i++) begin
         cycle($urandom_range(0, 99) < 45, rnd_grp(), $urandom_range(0, 99) < 65);
      end
      for (int i = 0; i < 12; i++) cycle(0, '0, 1);
      check("rnd_drained", 64'(out_valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
